// File: rtl/calc_mvd_cost_int64_hls_sdiv_64s_41ns_64_seq.sv
// Sequential signed divider: 64-bit signed dividend by a 41-bit unsigned divisor.
// Restoring radix-2 on the dividend magnitude, 66 enabled cycles from accept to result.
module calc_mvd_cost_int64_hls_sdiv_64s_41ns_64_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 64,
  parameter int din1_WIDTH = 41,
  parameter int dout_WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        start,
  input  logic [63:0] din0,
  input  logic [40:0] din1,
  output logic        ready,
  output logic        done,
  output logic [63:0] dout,
  output logic [41:0] rem,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] dvd_q, dvd_d;    // dividend magnitude; quotient bits shift in at the LSB
  logic [40:0] dvs_q, dvs_d;
  logic [41:0] prem_q, prem_d;
  logic        neg_q, neg_d;
  logic [63:0] dout_q, dout_d;
  logic [41:0] rem_q, rem_d;
  logic        div0_q, div0_d;
  logic        done_q, done_d;

  logic [41:0] shifted;
  logic [41:0] diff;
  logic        ge;

  assign shifted = {prem_q[40:0], dvd_q[63]};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ready   = (state_q == IDLE);

  // NOTE: every next-state signal gets a default before the case so no path
  // leaves it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    neg_d   = neg_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = din0[63] ? (64'd0 - din0) : din0;
          dvs_d   = din1;
          neg_d   = din0[63];
          prem_d  = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        prem_d = ge ? diff : shifted;
        dvd_d  = {dvd_q[62:0], ge};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd63) state_d = FIX;
      end
      FIX: begin
        // A zero divisor subtracts nothing, so prem already holds the low
        // 42 bits of the magnitude; only the quotient needs forcing.
        div0_d  = (dvs_q == '0);
        dout_d  = (dvs_q == '0) ? 64'd0 : (neg_q ? (64'd0 - dvd_q) : dvd_q);
        rem_d   = neg_q ? (42'd0 - prem_q) : prem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers sample
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      neg_q   <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      neg_q   <= neg_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign dout = dout_q;
  assign rem  = rem_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_calc_mvd_cost_int64_hls_sdiv_64s_41ns_64_seq.sv
// Directed bench for the sequential signed divider: latency, signs, divide by
// zero, clock-enable stalls, reset abort and back-to-back operation.
module tb_calc_mvd_cost_int64_hls_sdiv_64s_41ns_64_seq;

  logic        clk = 1'b0;
  logic        reset, ce, start;
  logic [63:0] din0;
  logic [40:0] din1;
  logic        ready, done, div0;
  logic [63:0] dout;
  logic [41:0] rem;

  int vectors    = 0;
  int miscompares = 0;

  calc_mvd_cost_int64_hls_sdiv_64s_41ns_64_seq dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .din0  (din0),
    .din1  (din1),
    .ready (ready),
    .done  (done),
    .dout  (dout),
    .rem   (rem),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [63:0] q, input logic [63:0] r,
                         input logic dz);
    chk({tag, ".dout"}, dout, q);
    chk({tag, ".rem"},  {22'd0, rem}, r);
    chk({tag, ".div0"}, {63'd0, div0}, {63'd0, dz});
  endtask

  // Accepts one operation and waits for done; lat counts edges from accept (=1).
  task automatic do_op(input logic [63:0] a, input logic [40:0] b,
                       input int stall_at, input int stall_len, output int lat);
    din0  = a;
    din1  = b;
    start = 1'b1;
    step();
    lat   = 1;
    start = 1'b0;
    while (done !== 1'b1 && lat < 300) begin
      if (lat == stall_at) ce = 1'b0;
      if (lat == stall_at + stall_len) ce = 1'b1;
      step();
      lat++;
    end
    ce = 1'b1;
  endtask

  logic [63:0] b2b_a [3];
  logic [40:0] b2b_b [3];
  logic [63:0] b2b_q [3];
  logic [63:0] b2b_r [3];

  initial begin
    int lat;
    int dones;

    reset = 1'b1; ce = 1'b0; start = 1'b0; din0 = '0; din1 = '0;
    step(); step();
    reset = 1'b0; ce = 1'b1;
    step();
    chk("reset.ready", {63'd0, ready}, 64'd1);
    chk("reset.done",  {63'd0, done},  64'd0);
    chk_res("reset", 64'd0, 64'd0, 1'b0);

    // 100 / 7
    do_op(64'd100, 41'd7, 0, 0, lat);
    chk("p100_7.lat", 64'(lat), 64'd66);
    chk("p100_7.ready", {63'd0, ready}, 64'd1);
    chk_res("p100_7", 64'd14, 64'd2, 1'b0);
    step();
    chk("p100_7.done_pulse", {63'd0, done}, 64'd0);
    chk("p100_7.dout_hold", dout, 64'd14);

    // -100 / 7
    do_op(-64'sd100, 41'd7, 0, 0, lat);
    chk("m100_7.lat", 64'(lat), 64'd66);
    chk_res("m100_7", 64'hFFFF_FFFF_FFFF_FFF2, 64'h3FF_FFFF_FFFE, 1'b0);

    // -2^63 / 1
    do_op(64'h8000_0000_0000_0000, 41'd1, 0, 0, lat);
    chk_res("min_1", 64'h8000_0000_0000_0000, 64'd0, 1'b0);

    // divide by zero, then a normal op
    do_op(64'd12345, 41'd0, 0, 0, lat);
    chk("dz.lat", 64'(lat), 64'd66);
    chk_res("dz", 64'd0, 64'd12345, 1'b1);
    do_op(64'd10, 41'd3, 0, 0, lat);
    chk_res("p10_3", 64'd3, 64'd1, 1'b0);

    // 1000 / (2^41-1) with a 10-cycle ce stall mid-CALC
    do_op(64'd1000, 41'h1FF_FFFF_FFFF, 20, 10, lat);
    chk("stall.lat", 64'(lat), 64'd76);
    chk_res("stall", 64'd0, 64'd1000, 1'b0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.done_held", {63'd0, done}, 64'd1);
    end
    ce = 1'b1;
    step();
    chk("stall.done_clear", {63'd0, done}, 64'd0);
    chk("stall.rem_hold", {22'd0, rem}, 64'd1000);

    // reset during CALC step 30 aborts the operation
    din0 = 64'd77; din1 = 41'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (30) step();
    chk("abort.busy", {63'd0, ready}, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.ready", {63'd0, ready}, 64'd1);
    chk("abort.done",  {63'd0, done},  64'd0);
    chk_res("abort", 64'd0, 64'd0, 1'b0);
    dones = 0;
    repeat (70) begin
      step();
      if (done === 1'b1) dones++;
    end
    chk("abort.no_done", 64'(dones), 64'd0);
    do_op(64'd9, 41'd2, 0, 0, lat);
    chk_res("p9_2", 64'd4, 64'd1, 1'b0);

    // reset wins over start in the same cycle
    step();
    din0 = 64'd50; din1 = 41'd5; start = 1'b1; reset = 1'b1;
    step();
    start = 1'b0; reset = 1'b0;
    dones = 0;
    repeat (70) begin
      step();
      if (done === 1'b1) dones++;
    end
    chk("rst_prio.no_done", 64'(dones), 64'd0);

    // back-to-back with start held high
    b2b_a[0] = 64'd1000000;            b2b_b[0] = 41'd3;
    b2b_q[0] = 64'd333333;             b2b_r[0] = 64'd1;
    b2b_a[1] = -64'sd7;                b2b_b[1] = 41'd2;
    b2b_q[1] = 64'hFFFF_FFFF_FFFF_FFFD; b2b_r[1] = 64'h3FF_FFFF_FFFF;
    b2b_a[2] = 64'h100_0000_0000;      b2b_b[2] = 41'd1024;
    b2b_q[2] = 64'h4000_0000;          b2b_r[2] = 64'd0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din0 = b2b_a[k];
      din1 = b2b_b[k];
      step();
      lat = 1;
      while (done !== 1'b1 && lat < 300) begin
        step();
        lat++;
      end
      chk($sformatf("b2b%0d.lat", k), 64'(lat), 64'd66);
      chk("b2b.ready", {63'd0, ready}, 64'd1);
      chk_res($sformatf("b2b%0d", k), b2b_q[k], b2b_r[k], 1'b0);
    end
    start = 1'b0;
    step();
    chk("b2b.end_done", {63'd0, done}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
